// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter: boot loader owns memory in BOOT, data port beats
// fetch in RUN unless fetch has been denied STARVE_MAX cycles in a row.
module mem_port_arbiter #(
   parameter int unsigned AW         = 11,
   parameter int unsigned DW         = 32,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          boot_en,
   output logic          boot_done,
   input  logic          ld_req,
   input  logic          ld_we,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_wdata,
   output logic          ld_gnt,
   output logic          ld_rvalid,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   output logic          dm_rvalid,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] rdata,
   output logic          mem_cen_n,
   output logic          mem_wen_n,
   output logic [AW-1:0] mem_a,
   output logic [DW-1:0] mem_d,
   input  logic [DW-1:0] mem_q
);

   localparam logic [0:0] S_BOOT = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_LD   = 2'd1;
   localparam logic [1:0] OWN_DM   = 2'd2;
   localparam logic [1:0] OWN_IF   = 2'd3;

   localparam int unsigned   SW         = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   logic [0:0]    state_q, state_d;
   logic [1:0]    owner_q, owner_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          if_prio;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_BOOT:  if (!boot_en) state_d = S_RUN;
         S_RUN:   if (boot_en)  state_d = S_BOOT;
         default: state_d = S_BOOT;
      endcase
   end

   assign boot_done = (state_q == S_RUN);
   assign if_prio   = (starve_q == STARVE_LIM);

   // Grants are forced low during reset so no access leaks out while rst is high.
   always_comb begin
      ld_gnt = 1'b0;
      dm_gnt = 1'b0;
      if_gnt = 1'b0;
      if (!rst) begin
         if (state_q == S_BOOT) begin
            ld_gnt = ld_req;
         end else begin
            if_gnt = if_req && (if_prio || !dm_req);
            dm_gnt = dm_req && !(if_req && (if_prio || !dm_req));
         end
      end
   end

   always_comb begin
      mem_cen_n = 1'b1;
      mem_wen_n = 1'b1;
      mem_a     = '0;
      mem_d     = '0;
      if (ld_gnt) begin
         mem_cen_n = 1'b0;
         mem_wen_n = ~ld_we;
         mem_a     = ld_addr;
         mem_d     = ld_wdata;
      end else if (dm_gnt) begin
         mem_cen_n = 1'b0;
         mem_wen_n = ~dm_we;
         mem_a     = dm_addr;
         mem_d     = dm_wdata;
      end else if (if_gnt) begin
         mem_cen_n = 1'b0;
         mem_a     = if_addr;
      end
   end

   always_comb begin
      owner_d = OWN_NONE;
      if (ld_gnt && !ld_we)      owner_d = OWN_LD;
      else if (dm_gnt && !dm_we) owner_d = OWN_DM;
      else if (if_gnt)           owner_d = OWN_IF;
   end

   always_comb begin
      starve_d = starve_q;
      if (state_q == S_BOOT || !if_req || if_gnt) starve_d = '0;
      else if (starve_q != STARVE_LIM)           starve_d = starve_q + SW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_BOOT;
         owner_q  <= OWN_NONE;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         starve_q <= starve_d;
      end
   end

   assign ld_rvalid = (owner_q == OWN_LD);
   assign dm_rvalid = (owner_q == OWN_DM);
   assign if_rvalid = (owner_q == OWN_IF);
   assign rdata     = mem_q;

   a_one_gnt: assert property (@(posedge clk) disable iff (rst)
      $onehot0({ld_gnt, dm_gnt, if_gnt}));

endmodule
